// File: rtl/mp64_nic_uart_bridge_if.sv
// Handshake bundle between a byte-serial link and a NIC-style frame port.
//   ser_rx_*  : length-prefixed bytes arriving from the serial side
//   ser_tx_*  : length-prefixed bytes leaving towards the serial side
//   phy_rx_*  : frame bytes delivered to the NIC (valid low = end of frame)
//   phy_tx_*  : frame bytes collected from the NIC
//   link_en / phy_link_up / err_pulse : link control and error status
// modport slave is the bridge view; modport master is the environment view.
interface mp64_nic_uart_bridge_if;
    logic       ser_rx_valid;
    logic [7:0] ser_rx_data;
    logic       ser_rx_ready;
    logic       ser_tx_valid;
    logic [7:0] ser_tx_data;
    logic       ser_tx_ready;
    logic       phy_rx_valid;
    logic [7:0] phy_rx_data;
    logic       phy_rx_ready;
    logic       phy_tx_valid;
    logic [7:0] phy_tx_data;
    logic       phy_tx_ready;
    logic       link_en;
    logic       phy_link_up;
    logic       err_pulse;

    modport slave (
        input  ser_rx_valid, ser_rx_data, ser_tx_ready, phy_rx_ready,
        input  phy_tx_valid, phy_tx_data, link_en,
        output ser_rx_ready, ser_tx_valid, ser_tx_data, phy_rx_valid, phy_rx_data,
        output phy_tx_ready, phy_link_up, err_pulse
    );

    modport master (
        output ser_rx_valid, ser_rx_data, ser_tx_ready, phy_rx_ready,
        output phy_tx_valid, phy_tx_data, link_en,
        input  ser_rx_ready, ser_tx_valid, ser_tx_data, phy_rx_valid, phy_rx_data,
        input  phy_tx_ready, phy_link_up, err_pulse
    );
endinterface

// File: rtl/mp64_nic_uart_bridge.sv
// Bridge between a byte-serial link carrying length-prefixed frames
// (LEN_LO, LEN_HI, payload) and a NIC frame port.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mp64_nic_uart_bridge_if.slave (serial rx/tx, phy rx/tx, link, error)
// RX path: buffers a whole serial frame, then emits it back-to-back to the NIC.
// TX path: collects a NIC frame, then sends header + payload on the serial side.
// The two paths share nothing except the OR-ed error pulse.
module mp64_nic_uart_bridge #(
    parameter int unsigned MTU = 1500
) (
    input  logic                          clk,
    input  logic                          rst,
    mp64_nic_uart_bridge_if.slave         bus
);

    localparam int unsigned AW     = (MTU > 1) ? $clog2(MTU) : 1;
    localparam logic [15:0] MtuLen = 16'(MTU);

    typedef enum logic [2:0] {
        RLen0, RLen1, RFill, RDrop, RWait, REmit, RGap
    } rx_state_e;

    typedef enum logic [1:0] {
        TCollect, THdr0, THdr1, TPay
    } tx_state_e;

    // ---------------- RX path ----------------
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_len_q, rx_len_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_we, rx_err, ser_rx_ready;
    logic [15:0] rx_len_full;
    logic [7:0]  rx_mem [MTU];

    assign rx_len_full = {bus.ser_rx_data, rx_len_q[7:0]};

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_len_d     = rx_len_q;
        rx_cnt_d     = rx_cnt_q;
        rx_data_d    = rx_data_q;
        rx_we        = 1'b0;
        rx_err       = 1'b0;
        ser_rx_ready = 1'b0;
        unique case (rx_state_q)
            RLen0: begin
                ser_rx_ready = 1'b1;
                if (bus.ser_rx_valid) begin
                    rx_len_d   = {8'h00, bus.ser_rx_data};
                    rx_state_d = RLen1;
                end
            end
            RLen1: begin
                ser_rx_ready = 1'b1;
                if (bus.ser_rx_valid) begin
                    rx_len_d = rx_len_full;
                    rx_cnt_d = '0;
                    if (rx_len_full == 16'd0) begin
                        rx_state_d = RLen0;
                    end else if (rx_len_full > MtuLen) begin
                        rx_state_d = RDrop;
                        rx_err     = 1'b1;
                    end else begin
                        rx_state_d = RFill;
                    end
                end
            end
            RFill: begin
                ser_rx_ready = 1'b1;
                if (bus.ser_rx_valid) begin
                    rx_we    = 1'b1;
                    rx_cnt_d = rx_cnt_q + 16'd1;
                    if (rx_cnt_q == rx_len_q - 16'd1) rx_state_d = RWait;
                end
            end
            RDrop: begin
                ser_rx_ready = 1'b1;
                if (bus.ser_rx_valid) begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                    if (rx_cnt_q == rx_len_q - 16'd1) rx_state_d = RLen0;
                end
            end
            RWait: begin
                // Preload byte 0 so it is on the bus in the first REmit cycle.
                if (bus.phy_rx_ready) begin
                    rx_data_d  = rx_mem[0];
                    rx_cnt_d   = 16'd1;
                    rx_state_d = REmit;
                end
            end
            REmit: begin
                // rx_cnt_q counts bytes already presented; once it hits the
                // length the current cycle carries the last byte.
                if (rx_cnt_q == rx_len_q) begin
                    rx_state_d = RGap;
                end else begin
                    rx_data_d = rx_mem[rx_cnt_q[AW-1:0]];
                    rx_cnt_d  = rx_cnt_q + 16'd1;
                end
            end
            RGap: begin
                rx_state_d = RLen0;
            end
            default: begin
                rx_state_d = RLen0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_we) rx_mem[rx_cnt_q[AW-1:0]] <= bus.ser_rx_data;
    end

    // ---------------- TX path ----------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] tx_idx_q, tx_idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_drop_q, tx_drop_d;
    logic        tx_we, tx_err;
    logic [7:0]  tx_mem [MTU];

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;
        tx_drop_d  = tx_drop_q;
        tx_we      = 1'b0;
        tx_err     = 1'b0;
        unique case (tx_state_q)
            TCollect: begin
                if (bus.phy_tx_valid) begin
                    if (tx_cnt_q < MtuLen) begin
                        tx_we    = 1'b1;
                        tx_cnt_d = tx_cnt_q + 16'd1;
                    end else if (!tx_drop_q) begin
                        // Only the first overflowing byte of a frame flags an error.
                        tx_err    = 1'b1;
                        tx_drop_d = 1'b1;
                    end
                end else if (tx_cnt_q != 16'd0) begin
                    tx_data_d  = tx_cnt_q[7:0];
                    tx_drop_d  = 1'b0;
                    tx_state_d = THdr0;
                end
            end
            THdr0: begin
                if (bus.ser_tx_ready) begin
                    tx_data_d  = tx_cnt_q[15:8];
                    tx_state_d = THdr1;
                end
            end
            THdr1: begin
                if (bus.ser_tx_ready) begin
                    tx_data_d  = tx_mem[0];
                    tx_idx_d   = 16'd1;
                    tx_state_d = TPay;
                end
            end
            TPay: begin
                if (bus.ser_tx_ready) begin
                    if (tx_idx_q == tx_cnt_q) begin
                        tx_cnt_d   = '0;
                        tx_state_d = TCollect;
                    end else begin
                        tx_data_d = tx_mem[tx_idx_q[AW-1:0]];
                        tx_idx_d  = tx_idx_q + 16'd1;
                    end
                end
            end
            default: begin
                tx_state_d = TCollect;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_we) tx_mem[tx_cnt_q[AW-1:0]] <= bus.phy_tx_data;
    end

    // ---------------- Shared state registers ----------------
    logic err_q, link_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RLen0;
            rx_len_q   <= '0;
            rx_cnt_q   <= '0;
            rx_data_q  <= '0;
            tx_state_q <= TCollect;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_data_q  <= '0;
            tx_drop_q  <= 1'b0;
            err_q      <= 1'b0;
            link_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_len_q   <= rx_len_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_data_q  <= rx_data_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_data_q  <= tx_data_d;
            tx_drop_q  <= tx_drop_d;
            err_q      <= rx_err | tx_err;
            link_q     <= bus.link_en;
        end
    end

    assign bus.ser_rx_ready = ser_rx_ready;
    assign bus.phy_rx_valid = (rx_state_q == REmit);
    assign bus.phy_rx_data  = rx_data_q;
    assign bus.phy_tx_ready = (tx_state_q == TCollect);
    assign bus.ser_tx_valid = (tx_state_q != TCollect);
    assign bus.ser_tx_data  = tx_data_q;
    assign bus.err_pulse    = err_q;
    assign bus.phy_link_up  = link_q;

endmodule
